// File: rtl/nx_rbus_target.sv
// nx_rbus_target: block-side register-bus target.
// Turns retimed rbus strobes into one local register access at a time.
// Reports ack or err_ack back to the retime stage, enforces an access
// timeout, and forwards the OR of the interrupt and ECC sources.
//
// Handshake: rbus_rd_stb/rbus_wr_stb are single-cycle requests. They are
// accepted only in IDLE, and every accepted strobe yields exactly one
// single-cycle rbus_ack or rbus_err_ack. Strobes seen outside IDLE are
// dropped and flagged on busy_drop. On the local side, reg_rd_en/reg_wr_en
// pulse once per access. reg_ack (with reg_rd_data/reg_err) completes the
// access and is honoured only in ACCESS/WAIT.
module nx_rbus_target #(
   parameter int          ADDR_W       = 10,
   parameter logic [15:0] REG_SPAN     = 16'h1000,
   parameter int          TIMEOUT_CYC  = 64,
   parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_0BAD,
   parameter int          NUM_INTR     = 4,
   parameter int          NUM_ECC      = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [15:0]         rbus_addr,
   input  logic                rbus_rd_stb,
   input  logic [31:0]         rbus_wr_data,
   input  logic                rbus_wr_stb,
   output logic                rbus_ack,
   output logic                rbus_err_ack,
   output logic [31:0]         rbus_rd_data,
   output logic                rbus_intr,
   output logic                rbus_ecc_error,
   output logic [ADDR_W-1:0]   reg_addr,
   output logic                reg_rd_en,
   output logic                reg_wr_en,
   output logic [31:0]         reg_wr_data,
   input  logic [31:0]         reg_rd_data,
   input  logic                reg_ack,
   input  logic                reg_err,
   input  logic [NUM_INTR-1:0] intr_src,
   input  logic [NUM_ECC-1:0]  ecc_src,
   output logic                busy_drop,
   output logic [1:0]          dbg_state
);

   localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic               is_rd_q;
   logic               resp_err_q;
   logic [31:0]        rd_data_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               busy_drop_q;
   logic               intr_q, ecc_q;
   logic [ADDR_W-1:0]  reg_addr_q;
   logic [31:0]        reg_wr_data_q;

   logic any_stb, legal, tmo_hit;

   assign any_stb = rbus_rd_stb | rbus_wr_stb;
   assign legal   = (rbus_rd_stb ^ rbus_wr_stb) && (rbus_addr[1:0] == 2'b00)
                    && (rbus_addr < REG_SPAN);
   // Counter starts at 0 in the first WAIT cycle; hitting TIMEOUT_CYC-2 here
   // means the next value would be TIMEOUT_CYC-1, which ends the wait.
   assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 2));

   assign rbus_rd_data   = rd_data_q;
   assign rbus_intr      = intr_q;
   assign rbus_ecc_error = ecc_q;
   assign reg_addr       = reg_addr_q;
   assign reg_wr_data    = reg_wr_data_q;
   assign busy_drop      = busy_drop_q;
   assign dbg_state      = state_q;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state decode and the per-state strobe outputs
   always_comb begin
      state_d      = state_q;
      reg_rd_en    = 1'b0;
      reg_wr_en    = 1'b0;
      rbus_ack     = 1'b0;
      rbus_err_ack = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_stb) state_d = legal ? ACCESS : RESP;
         end
         ACCESS: begin
            reg_rd_en = is_rd_q;
            reg_wr_en = !is_rd_q;
            state_d   = reg_ack ? RESP : WAIT;
         end
         WAIT: begin
            if (reg_ack || tmo_hit) state_d = RESP;
         end
         RESP: begin
            rbus_ack     = !resp_err_q;
            rbus_err_ack = resp_err_q;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Request capture, timeout counter and response data/error capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         is_rd_q       <= 1'b0;
         resp_err_q    <= 1'b0;
         rd_data_q     <= '0;
         cnt_q         <= '0;
         reg_addr_q    <= '0;
         reg_wr_data_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_stb) begin
                  if (legal) begin
                     is_rd_q       <= rbus_rd_stb;
                     reg_addr_q    <= rbus_addr[ADDR_W+1:2];
                     reg_wr_data_q <= rbus_wr_data;
                  end else begin
                     resp_err_q <= 1'b1;
                     rd_data_q  <= '0;
                  end
               end
            end
            ACCESS: begin
               cnt_q <= '0;
               if (reg_ack) begin
                  resp_err_q <= reg_err;
                  rd_data_q  <= is_rd_q ? reg_rd_data : 32'h0;
               end
            end
            WAIT: begin
               cnt_q <= cnt_q + 1'b1;
               if (reg_ack) begin
                  // ack wins over a timeout in the same cycle
                  resp_err_q <= reg_err;
                  rd_data_q  <= is_rd_q ? reg_rd_data : 32'h0;
               end else if (tmo_hit) begin
                  resp_err_q <= 1'b1;
                  rd_data_q  <= is_rd_q ? TIMEOUT_DATA : 32'h0;
               end
            end
            default: ;
         endcase
      end
   end

   // Busy-drop flag and registered interrupt / ECC aggregation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_drop_q <= 1'b0;
         intr_q      <= 1'b0;
         ecc_q       <= 1'b0;
      end else begin
         busy_drop_q <= (state_q != IDLE) && any_stb;
         intr_q      <= |intr_src;
         ecc_q       <= |ecc_src;
      end
   end

endmodule

// File: tb/tb_nx_rbus_target.sv
// Directed bench for nx_rbus_target with a response scoreboard.
module tb_nx_rbus_target;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] rbus_addr;
   logic        rbus_rd_stb, rbus_wr_stb;
   logic [31:0] rbus_wr_data;
   logic        rbus_ack, rbus_err_ack;
   logic [31:0] rbus_rd_data;
   logic        rbus_intr, rbus_ecc_error;
   logic [9:0]  reg_addr;
   logic        reg_rd_en, reg_wr_en;
   logic [31:0] reg_wr_data;
   logic [31:0] reg_rd_data;
   logic        reg_ack, reg_err;
   logic [3:0]  intr_src;
   logic [1:0]  ecc_src;
   logic        busy_drop;
   logic [1:0]  dbg_state;

   int cyc = 0;
   int checks = 0;
   int failures = 0;
   int rd_en_cnt = 0;
   int wr_en_cnt = 0;

   // {err, data, expected cycle}
   logic [64:0] exp_q[$];

   nx_rbus_target dut (
      .clk(clk), .rst_n(rst_n),
      .rbus_addr(rbus_addr), .rbus_rd_stb(rbus_rd_stb),
      .rbus_wr_data(rbus_wr_data), .rbus_wr_stb(rbus_wr_stb),
      .rbus_ack(rbus_ack), .rbus_err_ack(rbus_err_ack),
      .rbus_rd_data(rbus_rd_data), .rbus_intr(rbus_intr),
      .rbus_ecc_error(rbus_ecc_error), .reg_addr(reg_addr),
      .reg_rd_en(reg_rd_en), .reg_wr_en(reg_wr_en),
      .reg_wr_data(reg_wr_data), .reg_rd_data(reg_rd_data),
      .reg_ack(reg_ack), .reg_err(reg_err),
      .intr_src(intr_src), .ecc_src(ecc_src),
      .busy_drop(busy_drop), .dbg_state(dbg_state)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h cyc=%0d", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_push(input logic err, input logic [31:0] data, input int t);
      exp_q.push_back({err, data, 32'(t)});
   endtask

   // drive a strobe for one cycle; t is the strobe cycle T
   task automatic issue(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [31:0] data, output int t);
      rbus_rd_stb  = rd;
      rbus_wr_stb  = wr;
      rbus_addr    = addr;
      rbus_wr_data = data;
      t = cyc;
      step();
      rbus_rd_stb = 1'b0;
      rbus_wr_stb = 1'b0;
   endtask

   // monitor: local enable counts and scoreboard of rbus responses
   always @(negedge clk) begin
      logic [64:0] e;
      if (reg_rd_en) rd_en_cnt++;
      if (reg_wr_en) wr_en_cnt++;
      if (rbus_ack || rbus_err_ack) begin
         check32("ack_exclusive", {31'b0, rbus_ack & rbus_err_ack}, 32'h0);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_resp ack=%b err_ack=%b data=%h cyc=%0d",
                     rbus_ack, rbus_err_ack, rbus_rd_data, cyc);
         end else begin
            e = exp_q.pop_front();
            check32("resp_err_ack", {31'b0, rbus_err_ack}, {31'b0, e[64]});
            check32("resp_ack", {31'b0, rbus_ack}, {31'b0, ~e[64]});
            check32("resp_data", rbus_rd_data, e[63:32]);
            check32("resp_cycle", 32'(cyc), e[31:0]);
         end
      end
   end

   // directed stimulus
   initial begin
      int t, r0, w0;
      logic [15:0] ill_addr [3];
      logic        ill_rd   [3];
      logic        ill_wr   [3];
      ill_addr = '{16'h1000, 16'h0002, 16'h0008};
      ill_rd   = '{1'b1, 1'b0, 1'b1};
      ill_wr   = '{1'b0, 1'b1, 1'b1};

      rst_n = 1'b0;
      rbus_addr = '0; rbus_rd_stb = 0; rbus_wr_stb = 0; rbus_wr_data = '0;
      reg_rd_data = '0; reg_ack = 0; reg_err = 0;
      intr_src = 4'hF; ecc_src = 2'b11;
      repeat (3) step();

      // reset state
      check32("rst_ack", {31'b0, rbus_ack}, 0);
      check32("rst_err_ack", {31'b0, rbus_err_ack}, 0);
      check32("rst_rd_data", rbus_rd_data, 0);
      check32("rst_intr", {31'b0, rbus_intr}, 0);
      check32("rst_ecc", {31'b0, rbus_ecc_error}, 0);
      check32("rst_reg_en", {30'b0, reg_rd_en, reg_wr_en}, 0);
      check32("rst_busy_drop", {31'b0, busy_drop}, 0);
      check32("rst_state", {30'b0, dbg_state}, 0);
      intr_src = '0; ecc_src = '0;
      rst_n = 1'b1;
      repeat (2) step();

      // legal write, reg_ack 3 cycles after reg_wr_en
      w0 = wr_en_cnt; r0 = rd_en_cnt;
      issue(1'b0, 1'b1, 16'h0010, 32'hA5A5_0001, t);
      exp_push(1'b0, 32'h0, t + 5);
      check32("wr_en_t1", {31'b0, reg_wr_en}, 1);
      check32("wr_addr", {22'b0, reg_addr}, 32'd4);
      check32("wr_data", reg_wr_data, 32'hA5A5_0001);
      step();
      check32("wr_en_t2", {31'b0, reg_wr_en}, 0);
      repeat (2) step();
      reg_ack = 1'b1;
      step();
      reg_ack = 1'b0;
      repeat (2) step();
      check32("wr_en_count", 32'(wr_en_cnt - w0), 1);
      check32("wr_rd_en_count", 32'(rd_en_cnt - r0), 0);

      // legal read at top of span, ack in the ACCESS cycle
      issue(1'b1, 1'b0, 16'h0FFC, 32'h0, t);
      exp_push(1'b0, 32'h1234_5678, t + 2);
      reg_ack = 1'b1; reg_rd_data = 32'h1234_5678;
      check32("rd_en_t1", {31'b0, reg_rd_en}, 1);
      check32("rd_addr", {22'b0, reg_addr}, 32'h3FF);
      step();
      reg_ack = 1'b0; reg_rd_data = '0;
      repeat (3) step();
      check32("rd_data_hold", rbus_rd_data, 32'h1234_5678);

      // illegal: out of span, misaligned, both strobes
      w0 = wr_en_cnt; r0 = rd_en_cnt;
      for (int i = 0; i < 3; i++) begin
         issue(ill_rd[i], ill_wr[i], ill_addr[i], 32'hFFFF_FFFF, t);
         exp_push(1'b1, 32'h0, t + 1);
         repeat (2) step();
      end
      check32("ill_no_local", 32'((wr_en_cnt - w0) + (rd_en_cnt - r0)), 0);

      // timeout on a read, then a stray reg_ack
      issue(1'b1, 1'b0, 16'h0020, 32'h0, t);
      exp_push(1'b1, 32'hDEAD_0BAD, t + 65);
      repeat (70) step();
      reg_ack = 1'b1; reg_rd_data = 32'h5555_5555;
      step();
      reg_ack = 1'b0; reg_rd_data = '0;
      repeat (3) step();
      check32("tmo_data_hold", rbus_rd_data, 32'hDEAD_0BAD);
      check32("tmo_idle", {30'b0, dbg_state}, 0);

      // reg_err response plus a strobe dropped while busy
      issue(1'b1, 1'b0, 16'h0040, 32'h0, t);
      step();
      rbus_rd_stb = 1'b1; rbus_addr = 16'h0044;
      step();
      rbus_rd_stb = 1'b0;
      check32("busy_drop_pulse", {31'b0, busy_drop}, 1);
      reg_ack = 1'b1; reg_err = 1'b1; reg_rd_data = 32'hCAFE_F00D;
      exp_push(1'b1, 32'hCAFE_F00D, t + 4);
      step();
      reg_ack = 1'b0; reg_err = 1'b0; reg_rd_data = '0;
      check32("busy_drop_clear", {31'b0, busy_drop}, 0);
      repeat (4) step();

      // reset in the middle of a write
      issue(1'b0, 1'b1, 16'h0030, 32'h1111_2222, t);
      step();
      rst_n = 1'b0;
      #1;
      check32("mid_rst_resp", {30'b0, rbus_ack, rbus_err_ack}, 0);
      check32("mid_rst_rd_data", rbus_rd_data, 0);
      check32("mid_rst_reg", {reg_wr_en, reg_rd_en, reg_addr}, 0);
      check32("mid_rst_wr_data", reg_wr_data, 0);
      check32("mid_rst_state", {30'b0, dbg_state}, 0);
      step();
      rst_n = 1'b1;
      reg_ack = 1'b1;
      step();
      reg_ack = 1'b0;
      repeat (10) step();

      // interrupt / ECC aggregation
      intr_src = 4'b0100; ecc_src = 2'b00;
      #1;
      check32("intr_not_yet", {31'b0, rbus_intr}, 0);
      step();
      check32("intr_set", {31'b0, rbus_intr}, 1);
      check32("ecc_clear", {31'b0, rbus_ecc_error}, 0);
      intr_src = 4'b0000; ecc_src = 2'b10;
      step();
      check32("intr_clear", {31'b0, rbus_intr}, 0);
      check32("ecc_set", {31'b0, rbus_ecc_error}, 1);

      repeat (3) step();
      check32("queue_drained", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nx_rbus_target.md
Name: nx_rbus_target

Overview:
Block-side register-bus target that sits directly downstream of the per-block rbus retime stage. It consumes the retimed strobes, address and write data, and converts them into a single-outstanding local register access. It returns ack, err_ack and read data to the retime stage. It also detects illegal and timed-out accesses, and aggregates local interrupt and ECC-error sources onto the return path.

Parameters:
ADDR_W, 10, local word-address width; the block decodes byte span 4*2^ADDR_W.
REG_SPAN, 16'h1000, byte span of implemented registers; any address >= REG_SPAN is illegal.
TIMEOUT_CYC, 64, number of cycles to wait for reg_ack before forcing err_ack (minimum 2).
TIMEOUT_DATA, 32'hDEAD_0BAD, value driven on rbus_rd_data when a read times out.
NUM_INTR, 4, number of interrupt source bits.
NUM_ECC, 2, number of ECC error source bits.

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
rbus_addr  in  16  byte address from the retime stage
rbus_rd_stb  in  1  read strobe, single-cycle pulse
rbus_wr_data  in  32  write data
rbus_wr_stb  in  1  write strobe, single-cycle pulse
rbus_ack  out  1  access completed OK, single-cycle pulse
rbus_err_ack  out  1  access completed with error, single-cycle pulse
rbus_rd_data  out  32  read return data
rbus_intr  out  1  registered OR of intr_src
rbus_ecc_error  out  1  registered OR of ecc_src
reg_addr  out  ADDR_W  local word address (rbus_addr[ADDR_W+1:2])
reg_rd_en  out  1  local read request, single-cycle pulse
reg_wr_en  out  1  local write request, single-cycle pulse
reg_wr_data  out  32  local write data
reg_rd_data  in  32  local read data, valid with reg_ack
reg_ack  in  1  local access done
reg_err  in  1  local access error; qualified by reg_ack
intr_src  in  NUM_INTR  level interrupt sources
ecc_src  in  NUM_ECC  ECC error sources
busy_drop  out  1  pulse: a strobe arrived while busy and was dropped

Behaviour:
- Reset: all outputs are 0 and the FSM is in IDLE. Reset mid-access abandons the access; no ack is issued after reset release.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE, strobe in cycle T:
  - Legal: exactly one of rd_stb/wr_stb is set, rbus_addr[1:0]==0 and rbus_addr<REG_SPAN. The block registers reg_addr and reg_wr_data and goes to ACCESS.
  - Illegal (both strobes, misaligned or out of span): no local access. Go to RESP with error; rbus_err_ack pulses at T+1 and rbus_rd_data=0.
- ACCESS (cycle T+1): pulse reg_rd_en or reg_wr_en for exactly one cycle, clear the timeout counter, go to WAIT. reg_ack is sampled from this cycle onward.
- WAIT: the counter increments each cycle without reg_ack.
  - On reg_ack, capture the result (reg_rd_data for reads, 0 for writes) and the error flag (reg_err); go to RESP.
  - When the counter reaches TIMEOUT_CYC-1 without reg_ack, flag a timeout error; go to RESP.
  - reg_ack in the same cycle as the timeout: the ack wins.
- RESP: pulse exactly one of rbus_ack/rbus_err_ack for one cycle, then return to IDLE.
  - Timed-out read: rbus_rd_data=TIMEOUT_DATA. Timed-out write: rbus_rd_data=0.
  - rbus_rd_data holds its value until the next response.
- Latency:
  - Legal access with reg_ack in the ACCESS cycle: rbus_ack at T+2.
  - reg_ack k cycles after ACCESS: rbus_ack at T+2+k.
  - Timeout: rbus_err_ack at T+1+TIMEOUT_CYC.
- Busy handling: any strobe received outside IDLE is dropped, busy_drop pulses next cycle, and the state is unchanged.
- A stray reg_ack outside ACCESS/WAIT is ignored.
- rbus_intr = |intr_src and rbus_ecc_error = |ecc_src, each registered one cycle, independent of the FSM.
- Invariant: at most one of rbus_ack/rbus_err_ack is high, and each strobe accepted in IDLE produces exactly one response.

Test Plan:
- Legal write: addr=16'h0010, data=32'hA5A5_0001, reg_ack 3 cycles after reg_wr_en -> reg_addr=4, reg_wr_en pulses once at T+1, rbus_ack at T+5, rbus_rd_data=0.
- Legal read: addr=16'h0FFC, reg_ack with reg_rd_data=32'h1234_5678 in the ACCESS cycle -> reg_addr=10'h3FF, rbus_ack at T+2, rbus_rd_data=32'h1234_5678.
- Illegal accesses: addr=16'h1000; then addr=16'h0002; then rd_stb and wr_stb together -> rbus_err_ack at T+1 each time, no reg_rd_en/reg_wr_en.
- Timeout: read at 16'h0020, reg_ack never asserted -> rbus_err_ack at T+65, rbus_rd_data=32'hDEAD_0BAD. A later reg_ack is ignored.
- Error and busy: reg_ack with reg_err -> rbus_err_ack, no rbus_ack. A second rd_stb during WAIT -> busy_drop pulses, exactly one response in total.
- Reset and aggregation: assert rst_n low during WAIT -> all outputs 0, no response after release. intr_src=4'b0100 -> rbus_intr=1 one cycle later; ecc_src=0 -> rbus_ecc_error=0.
